seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Display-side consumer of the dynamic-lighting slot counter's output: takes the
//  2-bit scan-slot index (sequence 0,1,2,0,...) and drives the common-anode 3-digit
//  7-segment display.
//  Accepts a 3-digit BCD value through a valid/ready write port into a shadow buffer.
//  Commits the value tear-free at frame boundaries, inserts anti-ghosting dead time
//  on every digit change, and applies optional leading-zero suppression.
// PARAMETERS
//  DEAD_CYCLES  4  clock edges of all-anodes-off after each slot change (0 allowed)
// PORTS
//  CLK          in   1   system clock, all logic on posedge
//  RST_N        in   1   asynchronous, active-low reset
//  SLOT         in   2   scan-slot index from the slot counter; 2'b11 illegal
//  WR_EN        in   1   write request; accepted on an edge where WR_EN && WR_READY
//  WR_DATA      in   12  {d2,d1,d0} BCD nibbles, d2 = most significant digit
//  WR_DP        in   3   decimal-point enables {dp2,dp1,dp0}, captured with WR_DATA
//  WR_READY     out  1   shadow buffer empty; write will be accepted
//  LZ_SUPPRESS  in   1   1 = blank leading zeros (sampled live, not buffered)
//  SEG          out  7   {g,f,e,d,c,b,a}, active-low
//  DP           out  1   decimal point, active-low
//  AN           out  3   digit anodes, active-low, one-hot-low or all-off (3'b111)
// BEHAVIOUR
//  - Reset (async, RST_N=0):
//      AN=3'b111, SEG=7'h7F, DP=1, WR_READY=1.
//      active={0,0,0}, dp=0, pending empty, slot_q=0, state=DEAD, dead_cnt=0.
//  - Slot tracking: slot_q <= SLOT every edge.
//      A change is (SLOT != slot_q) on an edge.
//  - FSM states:
//      ON:   AN/SEG/DP show digit slot_q.
//      DEAD: AN=3'b111, SEG=7'h7F, DP=1.
//  - FSM transitions:
//      Change detected (any state) -> DEAD, dead_cnt <= 0, AN off at that same edge.
//      DEAD: dead_cnt increments each edge.
//      DEAD -> ON on the edge after dead_cnt reaches DEAD_CYCLES.
//      Net timing: AN off for exactly DEAD_CYCLES+1 edges; the new AN and SEG appear
//      together on edge DEAD_CYCLES+2 after SLOT changes.
//      DEAD_CYCLES=0: AN off for 1 edge.
//      A change during DEAD restarts the count.
//      SLOT=3: remain in DEAD with outputs off until SLOT is legal.
//  - Digit map: AN[k] low for slot k. Slot 0 = d0 (rightmost).
//  - Decode: 0-9 standard, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
//      Nibble 10-15 shows '-' (7'b0111111).
//  - Leading-zero suppression (LZ_SUPPRESS=1):
//      d2 blank if d2==0.
//      d1 blank if d2==0 && d1==0.
//      d0 always shown.
//      Blank = SEG 7'h7F with AN still driven; DP is unaffected by blanking.
//  - Write handshake:
//      Accept -> pending <= {WR_DATA,WR_DP}, WR_READY <= 0 on the same edge.
//      WR_EN while WR_READY=0 is ignored; there is no overwrite of pending.
//  - Commit: on an edge where SLOT==0 && slot_q==2 (frame boundary) and pending is full:
//      active <= pending, pending emptied, WR_READY <= 1.
//      A write presented at that edge is not accepted (WR_READY was 0).
//      It is accepted on the next edge if WR_EN is held.
//  - The new value becomes visible when the ON phase of slot 0 begins. Digits of a
//    frame never mix old and new values.
//  - A 2->1 or 1->0 jump still triggers dead time but no commit; only 2->0 commits.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - RST_N asserted mid-frame returns everything to reset values immediately.
//    A pending write is lost.
// STRUCTURE
//  - Shared package seven_seg_pkg:
//      SEG_BLANK=7'h7F, SEG_MINUS=7'b0111111, AN_OFF=3'b111.
//      Digit segment table.
//      FSM state encoding {DEAD, ON}.
//  - Sub-module seven_seg_decoder: combinational 4-bit nibble -> 7-bit active-low
//    segments, instantiated once on the muxed digit.
//  - Top: slot_q, FSM + dead counter, shadow/active buffers, LZ logic, output regs.
// TESTING
//  1. Reset with RST_N=0 mid-operation -> AN=111, SEG=7F, DP=1, WR_READY=1 at once,
//     asynchronously.
//  2. DEAD_CYCLES=4, active=12'h123, SLOT steps 0->1:
//     - AN=111 for 5 edges.
//     - Then AN=101, SEG=7'b0100100 ('2').
//  3. Write 12'h456 mid-frame:
//     - WR_READY drops the next edge.
//     - Slots 1,2 still show 2,1.
//     - At SLOT 2->0: WR_READY=1; slot 0 then shows '6'.
//  4. Second WR_EN with 12'h789 while WR_READY=0 -> ignored; the committed value
//     stays 12'h456.
//  5. LZ_SUPPRESS=1, value 12'h007:
//     - Slots 2,1 show SEG=7F.
//     - Slot 0 shows '7' (7'b1111000).
//     - With LZ_SUPPRESS=0, slots 2,1 show '0'.
//  6. Nibble 4'hB on d1 -> SEG=7'b0111111.
//     SLOT=3 -> AN=111 held until SLOT returns to 0..2.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, segment table and FSM encoding for the scan driver
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [2:0] AN_OFF    = 3'b111;

   // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
   localparam logic [6:0] SEG_DIGITS [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef enum logic {
      DEAD = 1'b0,
      ON   = 1'b1
   } disp_state_e;

   typedef struct packed {
      logic [11:0] data;
      logic [2:0]  dp;
   } disp_val_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - BCD nibble to active-low segment pattern, '-' for 10..15
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_MINUS;
      if (nibble_i <= 4'd9) seg_o = SEG_DIGITS[nibble_i];
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 3-digit common-anode scan driver with tear-free commit and dead time
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int DEAD_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [1:0]  SLOT,
   input  logic        WR_EN,
   input  logic [11:0] WR_DATA,
   input  logic [2:0]  WR_DP,
   output logic        WR_READY,
   input  logic        LZ_SUPPRESS,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic [2:0]  AN
);

   localparam int CW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEAD_CYCLES);

   logic [1:0]  slot_q;
   disp_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   disp_val_t   active_q, pend_q;
   logic        ready_q;
   logic [6:0]  seg_q, seg_d, seg_dec;
   logic        dp_q, dp_d;
   logic [2:0]  an_q, an_d;

   logic        change, frame_edge, accept, commit;
   logic [3:0]  nib;
   logic        dp_en, blank;
   logic [2:0]  an_sel;

   assign change     = (SLOT != slot_q);
   assign frame_edge = (SLOT == 2'd0) && (slot_q == 2'd2);
   assign accept     = WR_EN && ready_q;
   assign commit     = frame_edge && !ready_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= DEAD;
         cnt_q   <= '0;
         slot_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slot_q  <= SLOT;
      end
   end

   // The counter saturates so an illegal slot can park in DEAD indefinitely
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (change) begin
         state_d = DEAD;
         cnt_d   = '0;
      end else if (state_q == DEAD) begin
         if (cnt_q == CNT_MAX) begin
            if (slot_q != 2'd3) state_d = ON;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      nib    = active_q.data[3:0];
      dp_en  = active_q.dp[0];
      an_sel = 3'b110;
      blank  = 1'b0;
      case (slot_q)
         2'd1: begin
            nib    = active_q.data[7:4];
            dp_en  = active_q.dp[1];
            an_sel = 3'b101;
            blank  = LZ_SUPPRESS && (active_q.data[11:4] == 8'h00);
         end
         2'd2: begin
            nib    = active_q.data[11:8];
            dp_en  = active_q.dp[2];
            an_sel = 3'b011;
            blank  = LZ_SUPPRESS && (active_q.data[11:8] == 4'h0);
         end
         default: ;
      endcase
   end

   seven_seg_decoder u_dec (
      .nibble_i (nib),
      .seg_o    (seg_dec)
   );

   // Outputs follow the next state so AN and SEG switch on the same edge as the FSM
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_d == ON) begin
         an_d  = an_sel;
         seg_d = blank ? SEG_BLANK : seg_dec;
         dp_d  = ~dp_en;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         active_q <= '0;
         pend_q   <= '0;
         ready_q  <= 1'b1;
         an_q     <= AN_OFF;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b1;
      end else begin
         if (commit) begin
            active_q <= pend_q;
            ready_q  <= 1'b1;
         end else if (accept) begin
            pend_q  <= '{data: WR_DATA, dp: WR_DP};
            ready_q <= 1'b0;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign AN       = an_q;
   assign SEG      = seg_q;
   assign DP       = dp_q;
   assign WR_READY = ready_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

   localparam int D = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [1:0]  SLOT = 2'd0;
   logic        WR_EN = 1'b0;
   logic [11:0] WR_DATA = 12'h000;
   logic [2:0]  WR_DP = 3'b000;
   logic        LZ_SUPPRESS = 1'b0;
   logic        WR_READY;
   logic [6:0]  SEG;
   logic        DP;
   logic [2:0]  AN;

   seven_seg_scan_driver #(.DEAD_CYCLES(D)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .SLOT        (SLOT),
      .WR_EN       (WR_EN),
      .WR_DATA     (WR_DATA),
      .WR_DP       (WR_DP),
      .WR_READY    (WR_READY),
      .LZ_SUPPRESS (LZ_SUPPRESS),
      .SEG         (SEG),
      .DP          (DP),
      .AN          (AN)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       rdy;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   logic cur_lz = 1'b0;

   logic [11:0] m_val;
   logic [2:0]  m_dp;
   bit          m_pend;
   logic [11:0] m_pval;
   logic [2:0]  m_pdp;
   int          m_prev;
   int          m_since;

   function automatic logic [6:0] glyph(input int n);
      case (n)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Expected outputs after the coming edge, from the inputs now on the pins
   function automatic void model_edge();
      obs_t e;
      int   s;
      int   dg;
      bit   blank;
      e = '{an: 3'b111, seg: 7'h7F, dp: 1'b1, rdy: 1'b1};
      if (!RST_N) begin
         m_val = 12'h000; m_dp = 3'b000; m_pend = 1'b0;
         m_pval = 12'h000; m_pdp = 3'b000; m_prev = 0; m_since = 0;
      end else begin
         s = int'(SLOT);
         if (s == 0 && m_prev == 2 && m_pend) begin
            m_val = m_pval; m_dp = m_pdp; m_pend = 1'b0;
         end else if (WR_EN && !m_pend) begin
            m_pval = WR_DATA; m_pdp = WR_DP; m_pend = 1'b1;
         end
         if (s != m_prev) m_since = 0;
         else if (m_since < 1000) m_since = m_since + 1;
         m_prev = s;
         e.rdy = !m_pend;
         if (s != 3 && m_since > D) begin
            dg    = int'((m_val >> (4 * s)) & 12'hF);
            blank = cur_lz && (s > 0) && ((m_val >> (4 * s)) == 12'h000);
            e.an  = ~(3'b001 << s);
            e.seg = blank ? 7'h7F : glyph(dg);
            e.dp  = !m_dp[s];
         end
      end
      exp_q.push_back(e);
   endfunction

   initial begin
      obs_t e;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL scoreboard_underflow cyc=%0d", cyc);
            end else begin
               e = exp_q.pop_front();
               if ({AN, SEG, DP, WR_READY} === e) n_pass++;
               else $display("FAIL outputs cyc=%0d got AN=%b SEG=%b DP=%b RDY=%b want AN=%b SEG=%b DP=%b RDY=%b",
                             cyc, AN, SEG, DP, WR_READY, e.an, e.seg, e.dp, e.rdy);
            end
         end
      end
   end

   task automatic step(input logic rstn, input logic [1:0] s, input logic we,
                       input logic [11:0] d, input logic [2:0] p);
      @(negedge CLK);
      RST_N = rstn; SLOT = s; WR_EN = we; WR_DATA = d; WR_DP = p; LZ_SUPPRESS = cur_lz;
      model_edge();
      mon_en = 1'b1;
   endtask

   task automatic hold(input logic [1:0] s, input int n);
      repeat (n) step(1'b1, s, 1'b0, 12'h000, 3'b000);
   endtask

   task automatic write(input logic [1:0] s, input logic [11:0] d, input logic [2:0] p);
      step(1'b1, s, 1'b1, d, p);
   endtask

   task automatic async_reset();
      @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      n_checks++;
      if ({AN, SEG, DP, WR_READY} === {3'b111, 7'h7F, 1'b1, 1'b1}) n_pass++;
      else $display("FAIL async_reset got AN=%b SEG=%b DP=%b RDY=%b want AN=111 SEG=1111111 DP=1 RDY=1",
                    AN, SEG, DP, WR_READY);
      model_edge();
   endtask

   function automatic logic [11:0] rand_val();
      logic [11:0] v;
      for (int i = 0; i < 3; i++)
         v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      int rs;
      int nx;
      int dwell;
      repeat (3) step(1'b0, 2'd0, 1'b0, 12'h000, 3'b000);
      hold(0, 8);

      write(0, 12'h123, 3'b010);
      hold(0, 6); hold(1, 7); hold(2, 7); hold(0, 8);
      hold(1, 8);

      write(1, 12'h456, 3'b100);
      hold(1, 6); hold(2, 8);
      write(2, 12'h789, 3'b001);
      hold(2, 2); hold(0, 8); hold(1, 8); hold(2, 8); hold(0, 8);

      cur_lz = 1'b1;
      write(0, 12'h007, 3'b000);
      hold(1, 8); hold(2, 8); hold(0, 8); hold(1, 8); hold(2, 8);
      cur_lz = 1'b0;
      hold(2, 4); hold(1, 8);

      write(1, 12'h0B0, 3'b111);
      hold(2, 8); hold(0, 8); hold(1, 8);
      hold(3, 10); hold(0, 8);
      hold(1, 2); hold(2, 2); hold(0, 8);

      write(1, 12'h999, 3'b000);
      hold(1, 3);
      async_reset();
      step(1'b0, 2'd0, 1'b0, 12'h000, 3'b000);
      hold(0, 8); hold(1, 8); hold(2, 8); hold(0, 8);

      rs = 0;
      for (int it = 0; it < 1200; it++) begin
         nx = $urandom_range(0, 99);
         if (rs == 3) nx = $urandom_range(0, 2);
         else if (nx < 85) nx = (rs + 1) % 3;
         else if (nx < 95) nx = $urandom_range(0, 2);
         else nx = 3;
         rs = nx;
         if ($urandom_range(0, 9) == 0) cur_lz = ~cur_lz;
         dwell = $urandom_range(1, 12);
         for (int k = 0; k < dwell; k++)
            step(1'b1, 2'(rs), ($urandom_range(0, 3) == 0), rand_val(), 3'($urandom_range(0, 7)));
      end

      @(posedge CLK);
      #2;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
